alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 27 ++
 rtl/alu_sequencer.sv | 81 ++++++++
 tb/tb_alu_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Bundle of request, arithmetic-unit and result-handshake signals for alu_sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface alu_sequencer_if;
  logic        start;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [3:0]  opcode;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] result;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [15:0] out_result;
  logic        busy;
  logic        done;

  modport master (
    input  start, op_a, op_b, result, out_ready,
    output opcode, a, b, out_valid, out_opcode, out_result, busy, done
  );

  modport slave (
    output start, op_a, op_b, result, out_ready,
    input  opcode, a, b, out_valid, out_opcode, out_result, busy, done
  );
endinterface

// File: rtl/alu_sequencer.sv
// Steps an external arithmetic unit through opcodes 0..LAST_OP on latched operands,
// presenting each settled result on a valid/ready handshake.
module alu_sequencer #(
  parameter int unsigned LAST_OP       = 9,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  alu_sequencer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StDrive, StPresent, StDone} state_e;

  localparam logic [3:0] LastOp    = 4'(LAST_OP);
  localparam logic [3:0] SettleMax = 4'(SETTLE_CYCLES);

  state_e     state_q;
  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= 4'd0;
      bus.opcode     <= 4'd0;
      bus.a          <= 8'd0;
      bus.b          <= 8'd0;
      bus.out_valid  <= 1'b0;
      bus.out_opcode <= 4'd0;
      bus.out_result <= 16'd0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            bus.a      <= bus.op_a;
            bus.b      <= bus.op_b;
            bus.opcode <= 4'd0;
            cnt_q      <= 4'd0;
            bus.busy   <= 1'b1;
            state_q    <= StDrive;
          end
        end
        StDrive: begin
          // Capture lands SETTLE_CYCLES+1 edges after the opcode changes, so the
          // unit sees each opcode for at least SETTLE_CYCLES full cycles.
          if (cnt_q == SettleMax) begin
            bus.out_result <= bus.result;
            bus.out_opcode <= bus.opcode;
            bus.out_valid  <= 1'b1;
            state_q        <= StPresent;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StPresent: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (bus.opcode == LastOp) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state_q  <= StDone;
            end else begin
              bus.opcode <= bus.opcode + 4'd1;
              cnt_q      <= 4'd0;
              state_q    <= StDrive;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: default sequence with stall, busy-start, reset abort,
// and a single-step LAST_OP=0 / SETTLE_CYCLES=3 instance.
module tb_alu_sequencer;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  alu_sequencer_if bus0 ();
  alu_sequencer_if bus1 ();

  // Bench arithmetic unit model.
  assign bus0.result = 16'(bus0.a) + 16'(bus0.b) + 16'(bus0.opcode);
  assign bus1.result = 16'(bus1.a) + 16'(bus1.b) + 16'(bus1.opcode);

  alu_sequencer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  alu_sequencer #(
    .LAST_OP       (0),
    .SETTLE_CYCLES (3)
  ) u_dut_short (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus0.start = 1'b0; bus0.op_a = 8'd0; bus0.op_b = 8'd0; bus0.out_ready = 1'b0;
    bus1.start = 1'b0; bus1.op_a = 8'd0; bus1.op_b = 8'd0; bus1.out_ready = 1'b0;

    // Reset state, with start held high while rst_n is low.
    tick();
    bus0.start = 1'b1; bus0.op_a = 8'd15; bus0.op_b = 8'd3;
    tick();
    tick();
    check("rst_busy", 32'(bus0.busy), 0);
    check("rst_opcode", 32'(bus0.opcode), 0);
    check("rst_a", 32'(bus0.a), 0);
    check("rst_valid", 32'(bus0.out_valid), 0);
    check("rst_out_result", 32'(bus0.out_result), 0);
    check("rst_done", 32'(bus0.done), 0);
    bus0.start = 1'b0;
    rst_n = 1'b1;
    tick();

    // Main sequence: 10 results, 18..27.
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    check("start_busy", 32'(bus0.busy), 1);
    check("start_a", 32'(bus0.a), 15);
    check("start_b", 32'(bus0.b), 3);
    for (int k = 0; k <= 9; k++) begin
      w = 0;
      while (!bus0.out_valid && w < 20) begin
        tick();
        w++;
      end
      check("latency", 32'(w), 2);
      check("out_opcode", 32'(bus0.out_opcode), 32'(k));
      check("out_result", 32'(bus0.out_result), 32'(18 + k));
      check("busy_run", 32'(bus0.busy), 1);
      check("done_run", 32'(bus0.done), 0);
      if (k == 3) begin
        for (int s = 0; s < 5; s++) begin
          tick();
          check("stall_valid", 32'(bus0.out_valid), 1);
          check("stall_result", 32'(bus0.out_result), 21);
          check("stall_opcode", 32'(bus0.out_opcode), 3);
        end
      end
      if (k == 2) begin
        bus0.start = 1'b1;
        bus0.op_a  = 8'd1;
      end
      bus0.out_ready = 1'b1;
      tick();
      bus0.out_ready = 1'b0;
      bus0.start     = 1'b0;
      check("a_hold", 32'(bus0.a), 15);
      if (k < 9) check("valid_clear", 32'(bus0.out_valid), 0);
    end
    check("done_pulse", 32'(bus0.done), 1);
    check("done_busy", 32'(bus0.busy), 0);
    check("done_valid", 32'(bus0.out_valid), 0);
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    check("done_clear", 32'(bus0.done), 0);
    check("done_start_ignored", 32'(bus0.busy), 0);
    tick();
    check("idle_busy", 32'(bus0.busy), 0);

    // Reset abort during opcode 5.
    bus0.op_a  = 8'd15;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      w = 0;
      while (!bus0.out_valid && w < 20) begin
        tick();
        w++;
      end
      check("abort_opcode", 32'(bus0.out_opcode), 32'(k));
      if (k < 5) begin
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
      end
    end
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(bus0.out_valid), 0);
    check("abort_result", 32'(bus0.out_result), 0);
    check("abort_opcode_out", 32'(bus0.opcode), 0);
    check("abort_out_opcode", 32'(bus0.out_opcode), 0);
    check("abort_busy", 32'(bus0.busy), 0);
    check("abort_a", 32'(bus0.a), 0);
    tick();
    check("abort_no_done", 32'(bus0.done), 0);
    rst_n = 1'b1;
    tick();
    check("abort_no_done2", 32'(bus0.done), 0);
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    check("restart_opcode", 32'(bus0.opcode), 0);
    w = 0;
    while (!bus0.out_valid && w < 20) begin
      tick();
      w++;
    end
    check("restart_latency", 32'(w), 2);
    check("restart_out_opcode", 32'(bus0.out_opcode), 0);
    check("restart_result", 32'(bus0.out_result), 18);

    // LAST_OP=0, SETTLE_CYCLES=3 instance.
    bus1.op_a = 8'd15; bus1.op_b = 8'd3; bus1.out_ready = 1'b1;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("short_busy", 32'(bus1.busy), 1);
    w = 0;
    while (!bus1.out_valid && w < 20) begin
      tick();
      w++;
    end
    check("short_latency", 32'(w), 4);
    check("short_opcode", 32'(bus1.out_opcode), 0);
    check("short_result", 32'(bus1.out_result), 18);
    tick();
    check("short_done", 32'(bus1.done), 1);
    check("short_valid", 32'(bus1.out_valid), 0);
    check("short_busy_done", 32'(bus1.busy), 0);
    tick();
    check("short_done_clear", 32'(bus1.done), 0);
    check("short_idle", 32'(bus1.busy), 0);
    check("short_no_second", 32'(bus1.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
